// File: rtl/cpu_mul_seq.sv
// Sequential 32x32 -> 64 multiplier built on one registered 16x16 unsigned multiplier,
// with two's-complement correction on the high word. Optional macro: CPU_MUL_SEQ_EARLY_OUT_EN.
module cpu_mul_seq #(
    parameter int PP_W  = 16,
    parameter int ACC_W = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [2*PP_W-1:0] src1,
    input  logic [2*PP_W-1:0] src2,
    input  logic              src1_signed,
    input  logic              src2_signed,
    output logic              busy,
    output logic              done,
    output logic [2*PP_W-1:0] result_hi,
    output logic [2*PP_W-1:0] result_lo
);
    localparam int OP_W = 2 * PP_W;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, CORR} state_t;

    state_t            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [OP_W-1:0]   a_q, b_q;
    logic              s1_q, s2_q;
    logic [OP_W-1:0]   prod_q;
    logic              pv_q;
    logic [1:0]        pidx_q;
    logic [OP_W-1:0]   hi_q, lo_q;
    logic              done_q;
    logic              load, issue, fin, early_exit;
    logic [PP_W-1:0]   op_a, op_b;
    logic [ACC_W-1:0]  pp_ext;
    logic [5:0]        shamt;
    logic [OP_W-1:0]   corr_hi;

`ifdef CPU_MUL_SEQ_EARLY_OUT_EN
    // Both high halves zero: only P0 contributes and no sign correction applies.
    logic early_q;
    always_ff @(posedge clk) begin
        if (!reset_n)  early_q <= 1'b0;
        else if (load) early_q <= (src1[OP_W-1:PP_W] == '0) && (src2[OP_W-1:PP_W] == '0);
    end
    assign early_exit = early_q;
`else
    assign early_exit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        load    = 1'b0;
        issue   = 1'b0;
        fin     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    idx_d   = 2'd0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                issue = 1'b1;
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3 || early_exit) state_d = DRAIN;
            end
            DRAIN:   state_d = CORR;
            CORR: begin
                fin     = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // idx bit 0 selects the A half, bit 1 the B half: P0, P1, P2, P3 order.
    assign op_a = idx_q[0] ? a_q[OP_W-1:PP_W] : a_q[PP_W-1:0];
    assign op_b = idx_q[1] ? b_q[OP_W-1:PP_W] : b_q[PP_W-1:0];

    assign pp_ext = {{(ACC_W-OP_W){1'b0}}, prod_q};
    always_comb begin
        case (pidx_q)
            2'd0:    shamt = 6'd0;
            2'd3:    shamt = 6'd32;
            default: shamt = 6'd16;
        endcase
    end

    always_comb begin
        acc_d = acc_q;
        if (load)      acc_d = '0;
        else if (pv_q) acc_d = acc_q + (pp_ext << shamt);
    end

    // Signed operand with MSB set contributes -2^32 * other operand to the unsigned product.
    assign corr_hi = acc_q[ACC_W-1:OP_W]
                   - ((s1_q && a_q[OP_W-1]) ? b_q : '0)
                   - ((s2_q && b_q[OP_W-1]) ? a_q : '0);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            prod_q  <= '0;
            pv_q    <= 1'b0;
            pidx_q  <= 2'd0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            pv_q    <= issue;
            pidx_q  <= idx_q;
            done_q  <= fin;
            if (issue) prod_q <= op_a * op_b;
            if (load) begin
                a_q  <= src1;
                b_q  <= src2;
                s1_q <= src1_signed;
                s2_q <= src2_signed;
            end
            if (fin) begin
                hi_q <= corr_hi;
                lo_q <= acc_q[OP_W-1:0];
            end
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign result_hi = hi_q;
    assign result_lo = lo_q;
endmodule

// File: tb/tb_cpu_mul_seq.sv
// Scoreboard bench for cpu_mul_seq: stimulus pushes expected results and done cycle,
// a negedge monitor pops and compares on every done pulse.
module tb_cpu_mul_seq;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] src1 = '0, src2 = '0;
    logic        src1_signed = 1'b0, src2_signed = 1'b0;
    logic        busy, done;
    logic [31:0] result_hi, result_lo;

`ifdef CPU_MUL_SEQ_EARLY_OUT_EN
    localparam int LAT_S = 3;
`else
    localparam int LAT_S = 6;
`endif

    cpu_mul_seq dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .src1(src1), .src2(src2),
        .src1_signed(src1_signed), .src2_signed(src2_signed),
        .busy(busy), .done(done),
        .result_hi(result_hi), .result_lo(result_lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;
    exp_t q[$];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("result_hi", {32'd0, result_hi}, {32'd0, e.hi});
                chk("result_lo", {32'd0, result_lo}, {32'd0, e.lo});
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sa, input logic sb,
                         input logic [31:0] ehi, input logic [31:0] elo, input int lat, input bit push);
        exp_t e;
        @(negedge clk);
        start = 1'b1; src1 = a; src2 = b; src1_signed = sa; src2_signed = sb;
        if (push) begin
            e.hi = ehi; e.lo = elo; e.cyc = cyc + 1 + lat;
            q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0; src1 = 32'hDEADBEEF; src2 = 32'hCAFEF00D;
        src1_signed = ~sa; src2_signed = ~sb;
    endtask

    task automatic op(input logic [31:0] a, input logic [31:0] b, input logic sa, input logic sb,
                      input logic [31:0] ehi, input logic [31:0] elo, input int lat);
        issue(a, b, sa, sb, ehi, elo, lat, 1'b1);
        chk("busy_accept", {63'd0, busy}, 64'd1);
        for (int i = 1; i < lat; i++) begin
            @(negedge clk);
            chk("busy_inflight", {63'd0, busy}, 64'd1);
        end
        @(negedge clk);
        chk("busy_at_done", {63'd0, busy}, 64'd0);
        chk("done_pulse", {63'd0, done}, 64'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_hi", {32'd0, result_hi}, 64'd0);
        chk("rst_lo", {32'd0, result_lo}, 64'd0);
        reset_n = 1'b1;

        op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'hFFFFFFFE, 32'h00000001, 6);
        op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h00000000, 32'h00000001, 6);
        op(32'hFFFFFFFF, 32'h00000002, 1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFE, 6);
        op(32'h00000002, 32'hFFFFFFFF, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFE, 6);
        op(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b1, 32'h3FFFFFFF, 32'h00000001, 6);
        op(32'h0000FFFF, 32'h0000FFFF, 1'b0, 1'b0, 32'h00000000, 32'hFFFE0001, LAT_S);
        op(32'h00000007, 32'h00000009, 1'b1, 1'b1, 32'h00000000, 32'h0000003F, LAT_S);

        // Starts while busy are ignored; a start in the done cycle is taken.
        issue(32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 32'h0B00EA4E, 32'h242D2080, 6, 1'b1);
        for (int j = 1; j <= 5; j++) begin
            chk("busy_repulse", {63'd0, busy}, 64'd1);
            @(negedge clk);
            start = (j == 2 || j == 4);
            src1 = 32'h0000FFFF; src2 = 32'h00000003; src1_signed = 1'b1;
        end
        start = 1'b0;
        op(32'h80000000, 32'h80000000, 1'b1, 1'b1, 32'h40000000, 32'h00000000, 6);

        // Reset mid-operation discards the op without a done pulse.
        issue(32'hFFFFFFFF, 32'h12345678, 1'b1, 1'b1, 32'h0, 32'h0, 6, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_done", {63'd0, done}, 64'd0);
        chk("midrst_hi", {32'd0, result_hi}, 64'd0);
        chk("midrst_lo", {32'd0, result_lo}, 64'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("midrst_no_done", {63'd0, done}, 64'd0);
        end
        op(32'h00010000, 32'h00010000, 1'b0, 1'b0, 32'h00000001, 32'h00000000, 6);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
